// File: rtl/commit_bus_arbiter.sv
// Round-robin commit arbiter driving a registered commit bus, with stall and back-to-back grant masking.
// Optional conflict counter enabled by defining COMMIT_ARB_CONFLICT_CNT_EN.
module commit_bus_arbiter #(
  parameter int NUM_STATIONS = 5,
  parameter int PACKET_W     = 64,
  parameter int ID_W         = 3
) (
  input  logic                             Clock,
  input  logic                             Reset,
  input  logic [NUM_STATIONS-1:0]          iRequest,
  input  logic [NUM_STATIONS*PACKET_W-1:0] iCommitData,
  input  logic                             iStall,
`ifdef COMMIT_ARB_CONFLICT_CNT_EN
  input  logic                             iCountClear,
  output logic [15:0]                      oConflictCount,
`endif
  output logic [NUM_STATIONS-1:0]          oGrant,
  output logic                             oCommitValid,
  output logic [PACKET_W-1:0]              oCommitBus,
  output logic [ID_W-1:0]                  oGrantId
);

  function automatic logic [4:0] popcount(input logic [NUM_STATIONS-1:0] vec);
    logic [4:0] sum;
    sum = 5'd0;
    for (int k = 0; k < NUM_STATIONS; k++) begin
      sum = sum + {4'd0, vec[k]};
    end
    return sum;
  endfunction

  logic [NUM_STATIONS-1:0] eligible_s;
  logic                    any_s;
  logic [ID_W-1:0]         sel_s;
  logic [ID_W-1:0]         ptr_nxt_s;
  logic [NUM_STATIONS-1:0] grant_nxt_s;
  logic [PACKET_W-1:0]     bus_nxt_s;
  logic [ID_W-1:0]         ptr_r;

  // The station granted this cycle is masked so a falling request is not granted twice.
  assign eligible_s = iRequest & ~oGrant;
  assign any_s      = |eligible_s;

  // Pick the eligible station closest to the pointer going upward with wrap.
  always_comb begin
    int best_v;
    int dist_v;
    best_v = NUM_STATIONS;
    dist_v = 0;
    sel_s  = '0;
    for (int k = 0; k < NUM_STATIONS; k++) begin
      dist_v = (k >= int'(ptr_r)) ? (k - int'(ptr_r)) : (k + NUM_STATIONS - int'(ptr_r));
      if (eligible_s[k] && (dist_v < best_v)) begin
        best_v = dist_v;
        sel_s  = ID_W'(k);
      end else begin
        best_v = best_v;
      end
    end
  end

  // Decode the winner into a one-hot grant, its packet and the advanced pointer.
  always_comb begin
    grant_nxt_s = '0;
    bus_nxt_s   = '0;
    for (int k = 0; k < NUM_STATIONS; k++) begin
      grant_nxt_s[k] = (sel_s == ID_W'(k));
      bus_nxt_s      = bus_nxt_s |
                       ({PACKET_W{sel_s == ID_W'(k)}} & iCommitData[k*PACKET_W +: PACKET_W]);
    end
    ptr_nxt_s = (int'(sel_s) == NUM_STATIONS - 1) ? '0 : (sel_s + ID_W'(1));
  end

  // Commit bus, grant and round-robin pointer registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      oGrant       <= '0;
      oCommitValid <= 1'b0;
      oCommitBus   <= '0;
      oGrantId     <= '0;
      ptr_r        <= '0;
    end else if (!iStall && any_s) begin
      oGrant       <= grant_nxt_s;
      oCommitValid <= 1'b1;
      oCommitBus   <= bus_nxt_s;
      oGrantId     <= sel_s;
      ptr_r        <= ptr_nxt_s;
    end else begin
      oGrant       <= '0;
      oCommitValid <= 1'b0;
      oCommitBus   <= '0;
      oGrantId     <= '0;
      ptr_r        <= ptr_r;
    end
  end

`ifdef COMMIT_ARB_CONFLICT_CNT_EN
  // Saturating count of unstalled edges with two or more eligible stations; clear has priority.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      oConflictCount <= 16'd0;
    end else if (iCountClear) begin
      oConflictCount <= 16'd0;
    end else if (!iStall && (popcount(eligible_s) >= 5'd2) && (oConflictCount != 16'hFFFF)) begin
      oConflictCount <= oConflictCount + 16'd1;
    end else begin
      oConflictCount <= oConflictCount;
    end
  end
`endif

endmodule
